pc_stack_unit: RTL and testbench

Parametrised program-counter unit with a hardware return-address stack. It extends the processor's single-register PC with configurable address width, CALL/CALL_REL/RET instructions and overflow/underflow detection. It sits between the instruction decoder (opcode/operand) and the ALU flag register, and it drives the instruction-memory address bus.

---
 rtl/pc_stack_if.sv | 36 +++
 rtl/pc_stack_unit.sv | 142 ++++++++++++++
 tb/tb_pc_stack_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pc_stack_if.sv
// Decoder/flag side bundle for pc_stack_unit: instruction, operand, flags and
// control in, instruction-memory address and stack status out.
interface pc_stack_if #(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 8
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic                pc_enable;
  logic [15:0]         opcode;
  logic [PC_WIDTH-1:0] operand;
  logic [3:0]          flags;
  logic                read_enable;
  logic                fault_clear;

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_debug_output;
  logic [PC_WIDTH-1:0] stack_top;
  logic [CNT_W-1:0]    stack_count;
  logic                stack_empty;
  logic                stack_full;
  logic                overflow;
  logic                underflow;

  modport master (
    output pc_enable, opcode, operand, flags, read_enable, fault_clear,
    input  pc, pc_debug_output, stack_top, stack_count,
           stack_empty, stack_full, overflow, underflow
  );

  modport slave (
    input  pc_enable, opcode, operand, flags, read_enable, fault_clear,
    output pc, pc_debug_output, stack_top, stack_count,
           stack_empty, stack_full, overflow, underflow
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a LIFO return-address stack (CALL/CALL_REL/RET) and sticky
// overflow/underflow flags. Define PC_STACK_HALT_EN to freeze the PC while a fault is set.
module pc_stack_unit #(
  parameter int                     PC_WIDTH     = 16,
  parameter int                     STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
  input  logic       clk,
  input  logic       reset,
  pc_stack_if.slave  bus
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  localparam logic [3:0] OP_JMP      = 4'h0;
  localparam logic [3:0] OP_JMPC     = 4'h1;
  localparam logic [3:0] OP_JMPZ     = 4'h2;
  localparam logic [3:0] OP_JMP_REL  = 4'h3;
  localparam logic [3:0] OP_JMPC_REL = 4'h4;
  localparam logic [3:0] OP_JMPZ_REL = 4'h5;
  localparam logic [3:0] OP_CALL     = 4'h6;
  localparam logic [3:0] OP_CALL_REL = 4'h7;
  localparam logic [3:0] OP_RET      = 4'h8;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc, pc_rel, nxt_pc, top, fault_pc;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                push, pop, empty, full, halted;
  logic                is_grp, flag_c, flag_z;
  logic [3:0]          op;
  logic                unused_flags;

  assign unused_flags = &{1'b0, bus.flags[3:2]};

  assign pc_inc = pc_q + 1'b1;
  assign pc_rel = pc_q + bus.operand;
  assign is_grp = (bus.opcode[15:12] == 4'h7);
  assign op     = bus.opcode[11:8];
  assign flag_c = bus.flags[1];
  assign flag_z = bus.flags[0];

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(STACK_DEPTH));
  assign wr_idx = IDX_W'(cnt_q);
  assign rd_idx = IDX_W'(cnt_q - 1'b1);
  assign top    = empty ? '0 : stack_q[rd_idx];

`ifdef PC_STACK_HALT_EN
  assign halted   = ovf_q | unf_q;
  assign fault_pc = pc_q;
`else
  assign halted   = 1'b0;
  assign fault_pc = pc_inc;
`endif

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    push   = 1'b0;
    pop    = 1'b0;
    nxt_pc = pc_inc;
    // Clear first so a fault raised below in the same cycle wins.
    if (bus.fault_clear) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (bus.pc_enable) begin
      if (is_grp) begin
        case (op)
          OP_JMP:      nxt_pc = bus.operand;
          OP_JMPC:     if (flag_c) nxt_pc = bus.operand;
          OP_JMPZ:     if (flag_z) nxt_pc = bus.operand;
          OP_JMP_REL:  nxt_pc = pc_rel;
          OP_JMPC_REL: if (flag_c) nxt_pc = pc_rel;
          OP_JMPZ_REL: if (flag_z) nxt_pc = pc_rel;
          OP_CALL, OP_CALL_REL: begin
            if (full) begin
              ovf_d  = 1'b1;
              nxt_pc = fault_pc;
            end else begin
              push   = 1'b1;
              nxt_pc = (op == OP_CALL) ? bus.operand : pc_rel;
            end
          end
          OP_RET: begin
            if (empty) begin
              unf_d  = 1'b1;
              nxt_pc = fault_pc;
            end else begin
              pop    = 1'b1;
              nxt_pc = top;
            end
          end
          default: nxt_pc = pc_inc;
        endcase
      end
      // A halted unit still reports repeated faults but neither moves nor touches the stack.
      if (halted) begin
        push = 1'b0;
        pop  = 1'b0;
      end else begin
        pc_d = nxt_pc;
      end
    end
    if (push)     cnt_d = cnt_q + 1'b1;
    else if (pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) stack_q[wr_idx] <= pc_inc;
  end

  assign bus.pc              = bus.read_enable ? pc_q : 'z;
  assign bus.pc_debug_output = pc_q;
  assign bus.stack_top       = top;
  assign bus.stack_count     = cnt_q;
  assign bus.stack_empty     = empty;
  assign bus.stack_full      = full;
  assign bus.overflow        = ovf_q;
  assign bus.underflow       = unf_q;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed test of pc_stack_unit: branches, nested calls, stack faults, wrap and tri-state.
module tb_pc_stack_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_asrt = 0;
  int   n_fail = 0;

`ifdef PC_STACK_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  pc_stack_if #(.PC_WIDTH(16), .STACK_DEPTH(8)) bus ();

  pc_stack_unit #(
    .PC_WIDTH    (16),
    .STACK_DEPTH (8),
    .RESET_VECTOR(16'h0100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pcop(input logic [3:0] code);
    return {4'h7, code, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [15:0] opc, input logic [15:0] opd,
                      input logic [3:0] fl, input logic fc);
    bus.pc_enable   = en;
    bus.opcode      = opc;
    bus.operand     = opd;
    bus.flags       = fl;
    bus.fault_clear = fc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] ret_exp;
    logic [31:0] zexp;
    zexp = {16'h0000, {16{1'bz}}};
    reset           = 1'b1;
    bus.read_enable = 1'b1;
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0);
    chk("rst_pc",    32'(bus.pc_debug_output), 32'h0100);
    chk("rst_cnt",   32'(bus.stack_count), 32'd0);
    chk("rst_empty", 32'(bus.stack_empty), 32'd1);
    chk("rst_full",  32'(bus.stack_full), 32'd0);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_unf",   32'(bus.underflow), 32'd0);
    chk("rst_top",   32'(bus.stack_top), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) step(1'b1, 16'h0000, 16'h0000, 4'h0, 1'b0);
    chk("nop8_pc", 32'(bus.pc), 32'h0108);
    step(1'b0, pcop(4'h0), 16'h1234, 4'h0, 1'b0);
    chk("hold_pc", 32'(bus.pc_debug_output), 32'h0108);
    step(1'b1, pcop(4'h9), 16'h1234, 4'h0, 1'b0);
    chk("undef_op", 32'(bus.pc_debug_output), 32'h0109);
    step(1'b1, 16'h6000, 16'h1234, 4'h0, 1'b0);
    chk("non_grp", 32'(bus.pc_debug_output), 32'h010A);

    step(1'b1, pcop(4'h0), 16'h0010, 4'h0, 1'b0);
    chk("jmp", 32'(bus.pc_debug_output), 32'h0010);
    step(1'b1, pcop(4'h1), 16'h0040, 4'h0, 1'b0);
    chk("jmpc_nt", 32'(bus.pc_debug_output), 32'h0011);
    step(1'b1, pcop(4'h1), 16'h0040, 4'h2, 1'b0);
    chk("jmpc_t", 32'(bus.pc_debug_output), 32'h0040);
    step(1'b1, pcop(4'h5), 16'hFFFE, 4'h1, 1'b0);
    chk("jmpz_rel", 32'(bus.pc_debug_output), 32'h003E);
    step(1'b1, pcop(4'h3), 16'h0010, 4'h0, 1'b0);
    chk("jmp_rel", 32'(bus.pc_debug_output), 32'h004E);

    step(1'b1, pcop(4'h0), 16'h0005, 4'h0, 1'b0);
    step(1'b1, pcop(4'h6), 16'h0200, 4'h0, 1'b0);
    chk("call_pc",  32'(bus.pc_debug_output), 32'h0200);
    chk("call_top", 32'(bus.stack_top), 32'h0006);
    chk("call_cnt", 32'(bus.stack_count), 32'd1);
    step(1'b1, pcop(4'h8), 16'h0000, 4'h0, 1'b0);
    chk("ret_pc",    32'(bus.pc_debug_output), 32'h0006);
    chk("ret_empty", 32'(bus.stack_empty), 32'd1);

    // Nested calls: call i targets 0x1000 + i*0x10, from PC 0x0006.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, pcop(4'h6), 16'(16'h1000 + i * 16'h10), 4'h0, 1'b0);
      if (i == 7) chk("full_at7", 32'(bus.stack_full), 32'd0);
    end
    chk("full_at8", 32'(bus.stack_full), 32'd1);
    chk("cnt_at8",  32'(bus.stack_count), 32'd8);
    chk("top_at8",  32'(bus.stack_top), 32'h1071);
    step(1'b1, pcop(4'h6), 16'h1090, 4'h0, 1'b0);
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_pc",   32'(bus.pc_debug_output), HALT ? 32'h1080 : 32'h1081);
    chk("ovf_cnt",  32'(bus.stack_count), 32'd8);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1);
    chk("ovf_clr", 32'(bus.overflow), 32'd0);
    for (int i = 8; i >= 1; i--) begin
      ret_exp = (i == 1) ? 16'h0007 : 16'(16'h1000 + (i - 1) * 16'h10 + 1);
      step(1'b1, pcop(4'h8), 16'h0000, 4'h0, 1'b0);
      chk($sformatf("unwind_%0d", i), 32'(bus.pc_debug_output), 32'(ret_exp));
    end
    chk("unwind_empty", 32'(bus.stack_empty), 32'd1);

    step(1'b1, pcop(4'h8), 16'h0000, 4'h0, 1'b0);
    chk("unf_flag", 32'(bus.underflow), 32'd1);
    chk("unf_pc",   32'(bus.pc_debug_output), HALT ? 32'h0007 : 32'h0008);
    step(1'b1, pcop(4'h8), 16'h0000, 4'h0, 1'b1);
    chk("unf_clr_race", 32'(bus.underflow), 32'd1);
    chk("unf_race_pc",  32'(bus.pc_debug_output), HALT ? 32'h0007 : 32'h0009);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1);
    chk("unf_clr", 32'(bus.underflow), 32'd0);

    step(1'b1, pcop(4'h0), 16'hFFFF, 4'h0, 1'b0);
    chk("jmp_ffff", 32'(bus.pc_debug_output), 32'hFFFF);
    step(1'b1, pcop(4'h7), 16'h0003, 4'h0, 1'b0);
    chk("wrap_pc",  32'(bus.pc_debug_output), 32'h0002);
    chk("wrap_top", 32'(bus.stack_top), 32'h0000);
    chk("wrap_cnt", 32'(bus.stack_count), 32'd1);

    reset = 1'b1;
    step(1'b1, pcop(4'h0), 16'h1234, 4'h0, 1'b0);
    reset = 1'b0;
    chk("mid_rst_pc",  32'(bus.pc_debug_output), 32'h0100);
    chk("mid_rst_cnt", 32'(bus.stack_count), 32'd0);
    chk("mid_rst_top", 32'(bus.stack_top), 32'd0);

    bus.read_enable = 1'b0;
    #1;
    chk("pc_hiz", 32'(bus.pc), zexp);
    chk("dbg_driven", 32'(bus.pc_debug_output), 32'h0100);
    bus.read_enable = 1'b1;
    #1;
    chk("pc_driven", 32'(bus.pc), 32'h0100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
